// File: rtl/evg_pkg.sv
// Shared constants and helpers for the EVG event-generation blocks.
package evg_pkg;

    // Default event-code width used by the transmitter path.
    localparam int EVENTCODE_WIDTH_DEFAULT = 8;

    // Code that the transmitter treats as "nothing to send".
    localparam int EVCODE_IDLE = 0;

    // Width of a requester index; never narrower than one bit.
    function automatic int requesterIndexWidth(input int requesterCount);
        return (requesterCount > 2) ? $clog2(requesterCount) : 1;
    endfunction

endpackage

// File: rtl/evg_rr_select.sv
// Combinational first-set search over an eligibility vector, starting at
// startIndex and wrapping around modulo REQUESTER_COUNT.
module evg_rr_select
    import evg_pkg::*;
#(
    parameter int REQUESTER_COUNT = 4,
    parameter int INDEX_WIDTH     = requesterIndexWidth(REQUESTER_COUNT)
) (
    input  logic [REQUESTER_COUNT-1:0] eligible,
    input  logic [INDEX_WIDTH-1:0]     startIndex,
    output logic                       found,
    output logic [INDEX_WIDTH-1:0]     index
);

    // Pick the eligible requester with the smallest wrapped distance from startIndex.
    always_comb begin
        int bestDistance;
        int distance;
        found        = 1'b0;
        index        = '0;
        bestDistance = REQUESTER_COUNT;
        distance     = 0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (i >= int'(startIndex)) begin
                distance = i - int'(startIndex);
            end else begin
                distance = i + REQUESTER_COUNT - int'(startIndex);
            end
            if (eligible[i] && (distance < bestDistance)) begin
                bestDistance = distance;
                found        = 1'b1;
                index        = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/evg_event_arbiter.sv
// Merges several event-request streams into the single EVG transmitter slot
// stream: strict priority for the high class, round-robin for the low class,
// plus a saturating collision counter for diagnostics.
module evg_event_arbiter
    import evg_pkg::*;
#(
    parameter int REQUESTER_COUNT = 4,
    parameter int EVENTCODE_WIDTH = EVENTCODE_WIDTH_DEFAULT
) (
    input  logic                                       evgTxClk,
    input  logic                                       evgTxReset_n,
    input  logic [REQUESTER_COUNT*EVENTCODE_WIDTH-1:0] reqTDATA,
    input  logic [REQUESTER_COUNT-1:0]                 reqTVALID,
    output logic [REQUESTER_COUNT-1:0]                 reqTREADY,
    input  logic [REQUESTER_COUNT-1:0]                 highPriority,
    input  logic                                       evgTxSlot,
    output logic [EVENTCODE_WIDTH-1:0]                 evgTxCode,
    output logic                                       evgTxCodeValid,
    output logic [$clog2(REQUESTER_COUNT)-1:0]         lastGrant,
    output logic [15:0]                                collisionCount,
    input  logic                                       collisionClear
);

    localparam int IW = requesterIndexWidth(REQUESTER_COUNT);
    localparam logic [IW-1:0] LAST_INDEX = IW'(REQUESTER_COUNT - 1);
    localparam logic [EVENTCODE_WIDTH-1:0] IDLE_CODE = EVENTCODE_WIDTH'(EVCODE_IDLE);

    logic [REQUESTER_COUNT-1:0] highEligible;
    logic [REQUESTER_COUNT-1:0] lowEligible;
    logic                       highFound;
    logic                       lowFound;
    logic [IW-1:0]              highIndex;
    logic [IW-1:0]              lowIndex;
    logic [IW-1:0]              rrPtr;
    logic [IW-1:0]              rrStart;
    logic [IW-1:0]              winIndex;
    logic                       anyGrant;
    logic [REQUESTER_COUNT-1:0] grant;
    logic [EVENTCODE_WIDTH-1:0] winCode;
    logic                       transfer;
    logic                       contended;

    assign highEligible = reqTVALID & highPriority;
    assign lowEligible  = reqTVALID & ~highPriority;

    // Round-robin search starts just after the last low-class winner, wrapping at the top index.
    always_comb begin
        rrStart = (rrPtr == LAST_INDEX) ? '0 : rrPtr + 1'b1;
    end

    evg_rr_select #(
        .REQUESTER_COUNT (REQUESTER_COUNT),
        .INDEX_WIDTH     (IW)
    ) strictSelect (
        .eligible   (highEligible),
        .startIndex ('0),
        .found      (highFound),
        .index      (highIndex)
    );

    evg_rr_select #(
        .REQUESTER_COUNT (REQUESTER_COUNT),
        .INDEX_WIDTH     (IW)
    ) roundRobinSelect (
        .eligible   (lowEligible),
        .startIndex (rrStart),
        .found      (lowFound),
        .index      (lowIndex)
    );

    // Strict class overrides the round-robin class; grant is one-hot or zero.
    always_comb begin
        winIndex = highFound ? highIndex : lowIndex;
        anyGrant = highFound | lowFound;
        grant    = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            grant[i] = anyGrant && (winIndex == IW'(i));
        end
    end

    // Mux the winning requester's code out of the packed request bus.
    always_comb begin
        winCode = IDLE_CODE;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (grant[i]) begin
                winCode = reqTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH];
            end
        end
    end

    assign reqTREADY = {REQUESTER_COUNT{evgTxSlot & evgTxReset_n}} & grant;
    assign transfer  = evgTxSlot & anyGrant;
    assign contended = |(reqTVALID & (reqTVALID - 1'b1));

    // Register the transferred code; idle-code transfers and empty slots both present idle.
    always_ff @(posedge evgTxClk or negedge evgTxReset_n) begin
        if (!evgTxReset_n) begin
            evgTxCode      <= IDLE_CODE;
            evgTxCodeValid <= 1'b0;
        end else if (transfer && (winCode != IDLE_CODE)) begin
            evgTxCode      <= winCode;
            evgTxCodeValid <= 1'b1;
        end else begin
            evgTxCode      <= IDLE_CODE;
            evgTxCodeValid <= 1'b0;
        end
    end

    // Track the latest winner; the round-robin pointer moves only on low-class transfers.
    always_ff @(posedge evgTxClk or negedge evgTxReset_n) begin
        if (!evgTxReset_n) begin
            lastGrant <= '0;
            rrPtr     <= LAST_INDEX;
        end else if (transfer) begin
            lastGrant <= winIndex;
            if (!highFound) begin
                rrPtr <= lowIndex;
            end
        end
    end

    // Saturating count of slots with two or more requesters valid; clear wins over increment.
    always_ff @(posedge evgTxClk or negedge evgTxReset_n) begin
        if (!evgTxReset_n) begin
            collisionCount <= '0;
        end else if (collisionClear) begin
            collisionCount <= '0;
        end else if (evgTxSlot && contended && (collisionCount != 16'hFFFF)) begin
            collisionCount <= collisionCount + 16'd1;
        end
    end

endmodule

// File: doc/evg_event_arbiter.md
# evg_event_arbiter

Merges several event-request streams (hardware triggers, software requests, sequencer, heartbeat) into the single event-code slot stream fed to the EVG transmitter. Runs entirely in the `evgTxClk` domain. Each requester presents an AXI-stream-style code request. The arbiter grants at most one request per transmitter slot, using a two-class scheme: strict priority for the high class and round-robin for the low class. It also keeps a saturating collision counter for diagnostics.

## Interface
- `REQUESTER_COUNT`, 4: number of request streams; legal range 2..16.
- `EVENTCODE_WIDTH`, 8: event-code width.
- `evgTxClk`  in  1  transmitter clock; the only clock.
- `evgTxReset_n`  in  1  reset, asynchronous assert, active low.
- `reqTDATA`  in  REQUESTER_COUNT*EVENTCODE_WIDTH  request codes; requester i occupies bits [i*W +: W].
- `reqTVALID`  in  REQUESTER_COUNT  request valid, one bit per requester.
- `reqTREADY`  out  REQUESTER_COUNT  request accepted this cycle; combinational.
- `highPriority`  in  REQUESTER_COUNT  class select; 1 = strict class. Quasi-static.
- `evgTxSlot`  in  1  transmitter can take a code in this cycle.
- `evgTxCode`  out  EVENTCODE_WIDTH  registered event code to transmit.
- `evgTxCodeValid`  out  1  `evgTxCode` is a real event.
- `lastGrant`  out  $clog2(REQUESTER_COUNT)  index of the most recent granted requester.
- `collisionCount`  out  16  saturating count of contended slots.
- `collisionClear`  in  1  synchronous clear of `collisionCount`.

## Operation
- **Handshake.** A request transfers when `reqTVALID[i] & reqTREADY[i]` are both high.
- **Ready rule.** `reqTREADY[i] = evgTxSlot & grant[i]`.
  - `grant` is one-hot or zero.
  - `grant` depends only on `reqTVALID`, `highPriority` and the round-robin pointer, never on `reqTDATA`.
- **Strict class.** If any valid requester has `highPriority=1`, the lowest such index wins.
- **Round-robin class.** Otherwise the winner is the first valid requester at or after `rrPtr+1`, searching modulo REQUESTER_COUNT.
  - Only requesters with `highPriority=0` are eligible.
  - `rrPtr` is updated to the winner index only on a low-class transfer. Strict-class grants leave `rrPtr` unchanged.
- **No slot.** When `evgTxSlot=0`, all `reqTREADY` outputs are 0 and no state changes except the output registers, which load idle.
- **Output register.** On each clock edge:
  - After a transfer: `evgTxCode` = the transferred code, `evgTxCodeValid`=1.
  - Otherwise: `evgTxCode` = EVCODE_IDLE (0), `evgTxCodeValid`=0.
- **Idle-code request.** A transferred code equal to EVCODE_IDLE is accepted and discarded. Outputs stay idle, `lastGrant` still updates, and `rrPtr` updates per the normal rule.
- **Collisions.** `collisionCount` increments on each `evgTxSlot=1` cycle where popcount(`reqTVALID`) ≥ 2.
  - Saturates at 0xFFFF.
  - `collisionClear` has priority over an increment in the same cycle; the result is 0.
- **`highPriority` changes** take effect at the next arbitration cycle. Pending requests are never dropped; requesters hold TVALID until accepted.

## Timing
- **Reset values:** `evgTxCode`=0, `evgTxCodeValid`=0, `lastGrant`=0, `collisionCount`=0, `rrPtr`=REQUESTER_COUNT-1 (so requester 0 is first in round-robin).
- **Reset assert mid-operation:** all of the above load immediately and asynchronously. `reqTREADY` is forced to 0 while reset is asserted.
- **Release:** deassertion must be synchronized externally to `evgTxClk`. Arbitration starts on the first edge after release.
- **Latency:** the handshake happens in cycle N; the code is on `evgTxCode` with `evgTxCodeValid`=1 in cycle N+1, for exactly one cycle.
- **Throughput:** one transfer per slot cycle, so back-to-back slots give back-to-back codes.
- **Fairness:** a continuously valid low-class requester waits at most REQUESTER_COUNT-1 low-class grants. High-class traffic can starve the low class; this is by design.
- **Timing paths:** the ready path is combinational from `reqTVALID`/`evgTxSlot` to `reqTREADY`. The output code path is registered.

## Structure
- **Shared package `evg_pkg`:** EVCODE_IDLE, the default EVENTCODE_WIDTH, and a requester-index width function ($clog2 with a minimum of 1).
- **Sub-module `evg_rr_select`:** a combinational first-set search from a start index with wrap-around. Inputs are an eligibility vector and a start index; outputs are a found flag and an index.
  - It is used twice: strict class with start 0, round-robin class with start `rrPtr+1`.
  - `rrPtr+1` wraps to 0 at REQUESTER_COUNT-1; REQUESTER_COUNT need not be a power of two.

## Test plan
- **Reset then single request:** requester 2 valid with code 0x2A, `evgTxSlot`=1 → `reqTREADY`=4'b0100 that cycle; next cycle `evgTxCode`=0x2A, `evgTxCodeValid`=1, `lastGrant`=2.
- **Round-robin:** all four requesters valid (low class) with codes 0x11/0x22/0x33/0x44, slot continuously high → outputs 0x11, 0x22, 0x33, 0x44, 0x11…; `collisionCount` increments each cycle.
- **Strict class:** `highPriority`=4'b1000, all valid → requester 3 wins every slot; `rrPtr` is unchanged, so when requester 3 drops, the low class resumes from the earlier pointer position.
- **Slot gating:** requester 1 valid, `evgTxSlot` low for 5 cycles → `reqTREADY`=0 and `evgTxCodeValid`=0 throughout; code 0x55 transfers on the first slot-high cycle and appears one cycle later.
- **Saturation and clear:** preload 0xFFFE contended slots → `collisionCount` reaches 0xFFFF and holds. `collisionClear` asserted together with a collision → 0.
- **Idle code and reset:** requester 0 sends code 0x00 → transfer occurs, `evgTxCodeValid` stays 0. Asserting `evgTxReset_n`=0 in the cycle after a grant → `evgTxCode`/`evgTxCodeValid` go to 0 immediately.
